fetch_queue: RTL and testbench

Instruction prefetch queue between a handshaked, variable-latency instruction memory and the IF/ID pipeline register. It replaces the zero-latency combinational instruction ROM path. It keeps one memory request in flight, buffers up to DEPTH fetched words with their PC+4, and presents the oldest one to IF/ID. Branch and jump redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one request in flight to a handshaked memory,
// DEPTH-entry buffer of {inst, pc4}, flushed on redirect.
//
// state   | meaning
// IDLE    | no request outstanding; issue when not full
// WAIT    | request outstanding, response will be kept
// DISCARD | request outstanding, response belongs to a flushed path
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [31:0]   pc4_q  [DEPTH];
  logic [31:0]   pc4_d  [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic        push, pop, flush;
  logic [31:0] next_pc4;

  assign next_pc4  = req_addr_q + 32'd4;
  assign pop       = consume && (count_q != '0);

  assign out_valid = (count_q != '0);
  assign out_inst  = inst_q[rd_ptr_q];
  assign out_pc4   = pc4_q[rd_ptr_q];
  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = req_addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          flush      = 1'b1;
        end else if (count_q < DEPTH_CNT) begin
          req_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (redirect) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
          end else begin
            push       = 1'b1;
            fetch_pc_d = next_pc4;
          end
        end else if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = DISCARD;
        end
      end
      DISCARD: begin
        // the outstanding response is stale; only its ack can end the request
        if (redirect) fetch_pc_d = redirect_pc;
        if (mem_ack)  state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_d   = inst_q;
    pc4_d    = pc4_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        inst_d[wr_ptr_q] = mem_rdata;
        pc4_d[wr_ptr_q]  = next_pc4;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc4_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: transaction-level model (queue of {inst,pc4}) checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, redirect, consume, mem_ack;
  logic [31:0] redirect_pc, mem_rdata;
  logic        out_valid, mem_req;
  logic [31:0] out_inst, out_pc4, mem_addr;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .consume(consume), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc4(out_pc4), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model: next fetch address, outstanding request, whether its data is wanted
  logic [31:0] m_fetch, m_req;
  bit          m_pending, m_discard;
  logic [63:0] m_q[$];

  int          wait_cnt  = 0;
  int          lat_min   = 0;
  int          lat_max   = 0;
  bit          stray_en  = 0;
  bit          force_ack = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_fetch   = RESET_PC;
    m_req     = RESET_PC;
    m_pending = 0;
    m_discard = 0;
    m_q.delete();
  endfunction

  task automatic model_step(input logic r, input logic [31:0] rpc, input logic c,
                            input logic a, input logic [31:0] d);
    bit          fl = 0;
    bit          pu = 0;
    logic [63:0] ent = '0;
    if (!m_pending) begin
      if (r) begin
        m_fetch = rpc; fl = 1;
      end else if (m_q.size() < DEPTH) begin
        m_req = m_fetch; m_pending = 1;
      end
    end else if (!m_discard) begin
      if (a && !r) begin
        pu = 1; ent = {d, m_req + 32'd4}; m_fetch = m_req + 32'd4; m_pending = 0;
      end else if (a && r) begin
        fl = 1; m_fetch = rpc; m_pending = 0;
      end else if (r) begin
        fl = 1; m_fetch = rpc; m_discard = 1;
      end
    end else begin
      if (r) m_fetch = rpc;
      if (a) begin m_pending = 0; m_discard = 0; end
    end
    if (fl) m_q.delete();
    else begin
      if (c && m_q.size() > 0) void'(m_q.pop_front());
      if (pu) m_q.push_back(ent);
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_pending});
    chk("mem_addr", mem_addr, m_req);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("out_inst", out_inst, m_q[0][63:32]);
      chk("out_pc4", out_pc4, m_q[0][31:0]);
    end
  endtask

  // one cycle: called at a negedge, returns at the next negedge
  task automatic step(input logic r, input logic [31:0] rpc, input logic c);
    logic        a;
    logic [31:0] d;
    bit          was;
    check_outputs();
    if (m_pending) begin
      a = (wait_cnt == 0);
      if (wait_cnt > 0) wait_cnt--;
    end else begin
      a = force_ack || (stray_en && $urandom_range(0, 7) == 0);
    end
    d = use_fixed ? fixed_data : $urandom;
    redirect = r; redirect_pc = rpc; consume = c; mem_ack = a; mem_rdata = d;
    was = m_pending;
    @(posedge clk);
    model_step(r, rpc, c, a, d);
    if (!was && m_pending) wait_cnt = $urandom_range(lat_min, lat_max);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; consume = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc4", out_pc4, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h3000);
    rst = 1'b1;

    // single fetch with 1-cycle memory
    use_fixed = 1; fixed_data = 32'h2408_0005;
    step(0, 0, 0);
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h3000);
    step(0, 0, 0);
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_inst", out_inst, 32'h2408_0005);
    chk("first_pc4", out_pc4, 32'h3004);

    // fill to DEPTH and stall
    use_fixed = 0;
    repeat (6) step(0, 0, 0);
    chk("full_head_pc4", out_pc4, 32'h3004);
    repeat (3) step(0, 0, 0);
    chk("full_no_req", {31'b0, mem_req}, 32'd0);
    step(0, 0, 1);
    chk("pop_head_pc4", out_pc4, 32'h3008);
    chk("pop_no_req_yet", {31'b0, mem_req}, 32'd0);
    lat_min = 4; lat_max = 4;
    step(0, 0, 0);
    chk("refill_req", {31'b0, mem_req}, 32'd1);
    chk("refill_addr", mem_addr, 32'h3010);

    // redirect while waiting on a slow memory
    step(0, 0, 0);
    step(1, 32'h3040, 0);
    chk("redir_flush", {31'b0, out_valid}, 32'd0);
    chk("redir_hold_req", {31'b0, mem_req}, 32'd1);
    chk("redir_hold_addr", mem_addr, 32'h3010);
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 12 && !(mem_req && mem_addr == 32'h3040); i++) step(0, 0, 0);
    chk("redir_new_addr", mem_addr, 32'h3040);

    // redirect + ack + consume together
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 32'h5000, 1);
    chk("coinc_flush", {31'b0, out_valid}, 32'd0);
    step(0, 0, 0);
    chk("coinc_req", {31'b0, mem_req}, 32'd1);
    chk("coinc_addr", mem_addr, 32'h5000);

    // steady state: push and consume together at count 2
    for (int i = 0; i < 12 && m_q.size() < 2; i++) step(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, m_pending);
      chk("steady_valid", {31'b0, out_valid}, 32'd1);
    end

    // asynchronous reset in the middle of a request
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 6 && !(m_pending && wait_cnt > 1); i++) step(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_addr", mem_addr, 32'h3000);
    model_reset();
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    lat_min = 0; lat_max = 0;
    force_ack = 1;
    step(0, 0, 0);
    force_ack = 0;
    chk("stray_no_push", {31'b0, out_valid}, 32'd0);
    chk("stray_req_addr", mem_addr, 32'h3000);
    step(0, 0, 0);
    chk("after_rst_pc4", out_pc4, 32'h3004);

    // pc4 wraps past the top of the address space
    step(1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 20 && !out_valid; i++) step(0, 0, 0);
    chk("wrap_pc4", out_pc4, 32'h0);

    // random traffic
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      lat_max = $urandom_range(0, 5);
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
      step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 1) == 1);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
